// File: rtl/mic_sample_ram_writer.sv
// mic_sample_ram_writer: gathers one sample per mic into a frame, packs two per word,
// and writes frames into a ping-pong RAM buffer with host-acknowledged ready flags.
module mic_sample_ram_writer #(
  parameter int MIC_N  = 2,
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [16*MIC_N-1:0]  sample_data,
  input  logic [MIC_N-1:0]     sample_valid,
  input  logic [1:0]           host_ack,
  input  logic                 clear_status,
  output logic [ADDR_W-1:0]    ram_address,
  output logic                 ram_chipselect,
  output logic                 ram_write,
  output logic [31:0]          ram_writedata,
  output logic [3:0]           ram_byteenable,
  output logic [1:0]           buf_ready,
  output logic                 buf_overflow,
  output logic                 frame_overrun,
  output logic [31:0]          frame_count
);
  localparam int WPF = (MIC_N + 1) / 2;
  localparam int IW  = WPF > 1 ? $clog2(WPF) : 1;

  if (((1 << (ADDR_W - 1)) % WPF) != 0) begin : g_bad_geometry
    $error("RAM half size must be a multiple of words per frame");
  end

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [ADDR_W-1:0]      wr_ptr;
  logic [16*MIC_N-1:0]    cap;
  logic [MIC_N-1:0]       mask, new_mask;
  logic [32*WPF-1:0]      nxt_f, shd_f;
  logic                   done, dup, last, busy, accept, drop;
  logic [ADDR_W-2:0]      lo;
  logic                   h;

  // nxt_f is the frame as it stands after this cycle's valids, so a frame
  // completing now can be written out on the very next cycle
  for (genvar k = 0; k < MIC_N; k++) begin : g_ch
    assign nxt_f[16*k +: 16] = (enable && sample_valid[k]) ? sample_data[16*k +: 16] : cap[16*k +: 16];
  end
  if (MIC_N % 2) begin : g_pad
    assign nxt_f[32*WPF-1 -: 16] = 16'h0000;
  end

  assign new_mask = enable ? (mask | sample_valid) : '0;
  assign done     = enable && (&new_mask);
  assign dup      = enable && (|(mask & sample_valid));
  assign last     = (state == WRITE) && (idx == IW'(WPF - 1));
  assign busy     = (state == WRITE) && !last;
  assign accept   = done && !busy;
  assign drop     = done && busy;
  assign lo       = ram_address[ADDR_W-2:0];
  assign h        = ram_address[ADDR_W-1];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mask <= '0;
      cap  <= '0;
    end else begin
      mask <= done ? '0 : new_mask;
      cap  <= nxt_f[16*MIC_N-1:0];
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      wr_ptr         <= '0;
      shd_f          <= '0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      ram_byteenable <= '0;
      buf_ready      <= '0;
      buf_overflow   <= 1'b0;
      frame_overrun  <= 1'b0;
      frame_count    <= '0;
    end else begin
      if (accept || busy) begin
        state          <= WRITE;
        idx            <= accept ? '0 : idx + 1'b1;
        ram_address    <= wr_ptr;
        wr_ptr         <= wr_ptr + 1'b1;
        ram_chipselect <= 1'b1;
        ram_write      <= 1'b1;
        ram_byteenable <= 4'hF;
        ram_writedata  <= accept ? nxt_f[31:0] : shd_f[32*(int'(idx)+1) +: 32];
      end else begin
        state          <= IDLE;
        ram_chipselect <= 1'b0;
        ram_write      <= 1'b0;
        ram_byteenable <= 4'h0;
      end
      if (accept) shd_f <= nxt_f;
      if (last) frame_count <= frame_count + 1'b1;
      // flags are set from the write currently on the bus; sets beat clears
      buf_ready     <= (buf_ready & ~host_ack) | ((ram_write && (&lo)) ? (2'b01 << h) : 2'b00);
      buf_overflow  <= (buf_overflow & ~clear_status) | (ram_write && (lo == '0) && buf_ready[h]);
      frame_overrun <= (frame_overrun & ~clear_status) | dup | drop;
    end
endmodule

// File: tb/tb_mic_sample_ram_writer.sv
// tb_mic_sample_ram_writer: directed scoreboard bench for a 2-mic and a 3-mic instance.
module tb_mic_sample_ram_writer;
  typedef struct {logic [3:0] a; logic [31:0] d; int c;} exp_t;

  logic        clk = 0, reset = 1, enable = 1, clr = 0;
  logic [1:0]  ack = 0, sv2 = 0, ack3 = 0;
  logic [2:0]  sv3 = 0;
  logic [31:0] sd2 = 0;
  logic [47:0] sd3 = 0;
  logic        clr3 = 0;

  logic [3:0]  a2, a3;
  logic        cs2, w2, ov2, fo2, cs3, w3, ov3, fo3;
  logic [31:0] d2, d3, fc2, fc3;
  logic [3:0]  be2, be3;
  logic [1:0]  br2, br3;

  exp_t q2[$], q3[$];
  int   tests = 0, fails = 0, cyc = 0, ea = 0, efc = 0;

  mic_sample_ram_writer #(.MIC_N(2), .ADDR_W(4)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .sample_data(sd2), .sample_valid(sv2),
    .host_ack(ack), .clear_status(clr), .ram_address(a2), .ram_chipselect(cs2),
    .ram_write(w2), .ram_writedata(d2), .ram_byteenable(be2), .buf_ready(br2),
    .buf_overflow(ov2), .frame_overrun(fo2), .frame_count(fc2));

  mic_sample_ram_writer #(.MIC_N(3), .ADDR_W(4)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .sample_data(sd3), .sample_valid(sv3),
    .host_ack(ack3), .clear_status(clr3), .ram_address(a3), .ram_chipselect(cs3),
    .ram_write(w3), .ram_writedata(d3), .ram_byteenable(be3), .buf_ready(br3),
    .buf_overflow(ov3), .frame_overrun(fo3), .frame_count(fc3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (w2) begin
    exp_t e;
    tests++;
    if (q2.size() == 0) begin
      fails++;
      $display("FAIL wr2 unexpected write addr=%0h data=%h cycle=%0d", a2, d2, cyc);
    end else begin
      e = q2.pop_front();
      if (a2 !== e.a || d2 !== e.d || be2 !== 4'hF || cs2 !== 1'b1 || cyc != e.c) begin
        fails++;
        $display("FAIL wr2 got addr=%0h data=%h be=%h cs=%b cyc=%0d exp addr=%0h data=%h be=f cs=1 cyc=%0d",
                 a2, d2, be2, cs2, cyc, e.a, e.d, e.c);
      end
    end
  end

  always @(negedge clk) if (w3) begin
    exp_t e;
    tests++;
    if (q3.size() == 0) begin
      fails++;
      $display("FAIL wr3 unexpected write addr=%0h data=%h cycle=%0d", a3, d3, cyc);
    end else begin
      e = q3.pop_front();
      if (a3 !== e.a || d3 !== e.d || be3 !== 4'hF || cs3 !== 1'b1 || cyc != e.c) begin
        fails++;
        $display("FAIL wr3 got addr=%0h data=%h be=%h cs=%b cyc=%0d exp addr=%0h data=%h be=f cs=1 cyc=%0d",
                 a3, d3, be3, cs3, cyc, e.a, e.d, e.c);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic expect2(input logic [31:0] d);
    logic [31:0] av;
    av = ea;
    q2.push_back('{av[3:0], d, cyc + 1});
    ea  = (ea + 1) % 16;
    efc = efc + 1;
  endtask

  // full frame on both channels; ak is pulsed during the resulting write cycle
  task automatic frame2(input logic [15:0] c0, input logic [15:0] c1, input logic [1:0] ak);
    expect2({c1, c0});
    sd2 = {c1, c0};
    sv2 = 2'b11;
    tick;
    sv2 = 2'b00;
    ack = ak;
    tick;
    ack = 2'b00;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_write", {31'd0, w2}, 0);
    chk("rst_cs_be", {27'd0, cs2, be2}, 0);
    chk("rst_addr_data", {a2, d2[27:0]}, 0);
    chk("rst_flags", {28'd0, br2, ov2, fo2}, 0);
    chk("rst_fcount", fc2, 0);
    reset = 0;
    tick;

    frame2(16'h1234, 16'hABCD, 2'b00);
    chk("single_fcount", fc2, 1);
    chk("single_drained", q2.size(), 0);

    sd2 = {16'h0, 16'h1111}; sv2 = 2'b01; tick; sv2 = 0; tick;
    sd2 = {16'h0, 16'h2222}; sv2 = 2'b01; tick; sv2 = 0; tick;
    expect2(32'h3333_2222);
    sd2 = {16'h3333, 16'h0}; sv2 = 2'b10; tick; sv2 = 0; tick;
    chk("stagger_overrun", {31'd0, fo2}, 1);
    chk("stagger_drained", q2.size(), 0);

    clr = 1; tick; clr = 0;
    chk("clear_overrun", {31'd0, fo2}, 0);

    for (int i = 2; i < 8; i++) frame2(16'(i), 16'(i + 'h100), 2'b00);
    chk("half0_ready", {30'd0, br2}, 2'b01);
    chk("half0_no_ovf", {31'd0, ov2}, 0);

    for (int i = 8; i < 15; i++) frame2(16'(i), 16'(i + 'h100), 2'b00);
    chk("half1_not_yet", {30'd0, br2}, 2'b01);
    frame2(16'h000F, 16'h010F, 2'b10);
    chk("ack_race_set_wins", {30'd0, br2}, 2'b11);
    ack = 2'b10; tick; ack = 0;
    chk("ack_clears", {30'd0, br2}, 2'b01);

    frame2(16'hBEEF, 16'hCAFE, 2'b00);
    chk("wrap_overflow", {31'd0, ov2}, 1);
    chk("wrap_ready_held", {30'd0, br2}, 2'b01);
    chk("fcount_17", fc2, efc);

    enable = 0;
    for (int i = 0; i < 6; i++) begin
      sd2 = {16'(i), 16'(i + 7)};
      sv2 = 2'(i + 1);
      tick;
    end
    sv2 = 0; tick;
    chk("disabled_fcount", fc2, efc);
    sd2 = {16'h0, 16'hDEAD}; sv2 = 2'b01; tick;
    enable = 1;
    sd2 = {16'h5555, 16'h0}; sv2 = 2'b10; tick; sv2 = 0; tick; tick;
    chk("reenable_no_write", fc2, efc);
    expect2(32'h5555_6666);
    sd2 = {16'h0, 16'h6666}; sv2 = 2'b01; tick; sv2 = 0; tick;
    chk("reenable_frame", fc2, efc);
    chk("disabled_no_overrun", {31'd0, fo2}, 0);

    q3.push_back('{4'd0, 32'h0002_0001, cyc + 1});
    q3.push_back('{4'd1, 32'h0000_0003, cyc + 2});
    sd3 = {16'h0003, 16'h0002, 16'h0001}; sv3 = 3'b111; tick; sv3 = 0; tick; tick;
    chk("odd_drained", q3.size(), 0);
    chk("odd_fcount", fc3, 1);
    chk("odd_flags", {28'd0, br3, ov3, fo3}, 0);

    reset = 1; tick; reset = 0; tick;
    ea = 0; efc = 0;
    for (int i = 1; i < 5; i++) frame2(16'(i), 16'(i * 3), 2'b00);
    chk("pre_reset_fcount", fc2, 4);
    sd2 = 32'h7777_8888; sv2 = 2'b11; tick; sv2 = 0;
    reset = 1;
    #1;
    chk("reset_mid_write", {30'd0, w2, cs2}, 0);
    tick;
    reset = 0;
    chk("post_reset_ready", {30'd0, br2}, 0);
    chk("post_reset_fcount", fc2, 0);
    ea = 0; efc = 0;
    frame2(16'h4242, 16'h2424, 2'b00);
    chk("post_reset_frame", fc2, 1);
    chk("final_q2_empty", q2.size(), 0);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
